// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_pkg
//  Purpose  : Shared constants for the ALU execute unit: 5-bit internal op
//             codes, alu_op encodings from the main decoder, funct7 selector
//             values and the execute FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    // Internal op codes. Bit 4 marks an RV32M op; for those, bit 2 splits
    // multiply (0) from divide/remainder (1), and bits [2:0] equal funct3.
    localparam logic [4:0] c_OP_ADD    = 5'd0;
    localparam logic [4:0] c_OP_SUB    = 5'd1;
    localparam logic [4:0] c_OP_XOR    = 5'd2;
    localparam logic [4:0] c_OP_OR     = 5'd3;
    localparam logic [4:0] c_OP_AND    = 5'd4;
    localparam logic [4:0] c_OP_SLL    = 5'd5;
    localparam logic [4:0] c_OP_SRL    = 5'd6;
    localparam logic [4:0] c_OP_SRA    = 5'd7;
    localparam logic [4:0] c_OP_SLT    = 5'd8;
    localparam logic [4:0] c_OP_SLTU   = 5'd9;
    localparam logic [4:0] c_OP_MUL    = 5'd16;
    localparam logic [4:0] c_OP_MULH   = 5'd17;
    localparam logic [4:0] c_OP_MULHSU = 5'd18;
    localparam logic [4:0] c_OP_MULHU  = 5'd19;
    localparam logic [4:0] c_OP_DIV    = 5'd20;
    localparam logic [4:0] c_OP_DIVU   = 5'd21;
    localparam logic [4:0] c_OP_REM    = 5'd22;
    localparam logic [4:0] c_OP_REMU   = 5'd23;

    // alu_op encodings produced by the main instruction decoder
    localparam logic [1:0] c_ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] c_ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] c_ALU_OP_ITYPE  = 2'b11;

    // funct7 selector values
    localparam logic [6:0] c_FUNCT7_ALT  = 7'd32;
    localparam logic [6:0] c_FUNCT7_MEXT = 7'd1;

    // Execute FSM states
    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_MUL      = 2'd1;
    localparam logic [1:0] c_ST_DIV      = 2'd2;
    localparam logic [1:0] c_ST_DONE_DIV = 2'd3;

    function automatic logic is_mul_op(input logic [4:0] op);
        return op[4] && !op[2];
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return op[4] && op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_decode.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_decode
//  Purpose  : Combinational decode of alu_op/funct3/funct7 into the 5-bit
//             internal op code. Kept separate so hazard logic can reuse it.
//  Ports    : alu_op [1:0]  in   decoder class (add / branch / R / I)
//             funct3 [2:0]  in   instruction funct3
//             funct7 [6:0]  in   instruction funct7 (imm[11:5] for I-type)
//             op     [4:0]  out  internal op code
//  Params   : M_EXT - 1 decodes RV32M ops on R-type funct7 == 1
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_exec_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [4:0] op
);

    logic       w_alt;
    logic [4:0] w_base_op;

    assign w_alt = (funct7 == c_FUNCT7_ALT);

    // RV32I mapping shared by R-type and I-type; funct3 0 with the alternate
    // funct7 is SUB only for R-type, and is patched below.
    always_comb begin
        w_base_op = c_OP_ADD;
        case (funct3)
            3'd0:    w_base_op = c_OP_ADD;
            3'd1:    w_base_op = c_OP_SLL;
            3'd2:    w_base_op = c_OP_SLT;
            3'd3:    w_base_op = c_OP_SLTU;
            3'd4:    w_base_op = c_OP_XOR;
            3'd5:    w_base_op = w_alt ? c_OP_SRA : c_OP_SRL;
            3'd6:    w_base_op = c_OP_OR;
            default: w_base_op = c_OP_AND;
        endcase
    end

    always_comb begin
        op = c_OP_ADD;
        case (alu_op)
            c_ALU_OP_ADD: op = c_OP_ADD;
            c_ALU_OP_BRANCH: begin
                case (funct3)
                    3'd4, 3'd5: op = c_OP_SLT;
                    3'd6, 3'd7: op = c_OP_SLTU;
                    default:    op = c_OP_SUB;
                endcase
            end
            c_ALU_OP_RTYPE: begin
                if ((M_EXT != 0) && (funct7 == c_FUNCT7_MEXT))
                    op = {2'b10, funct3};
                else if ((funct3 == 3'd0) && w_alt)
                    op = c_OP_SUB;
                else
                    op = w_base_op;
            end
            default: begin
                // I-type: the immediate's upper bits matter only for SRAI
                op = (funct3 == 3'd0) ? c_OP_ADD : w_base_op;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Handshaked EX-stage execute unit. Base ALU ops complete in one
//             cycle; RV32M multiply (shift-add) and divide (restoring) iterate
//             XLEN steps on operand magnitudes with a final sign fix.
//  Ports    : clk, rst (async, active high), flush (sync abort)
//             in_valid/in_ready      operation handshake
//             alu_op, funct3, funct7 operation select
//             op_a, op_b [XLEN]      operands
//             out_valid/out_ready    result handshake
//             result [XLEN]          registered result
//             result_zero            result == 0
//  Params   : XLEN  - operand width (>= 8, power of 2)
//             M_EXT - 1 enables RV32M decode
//  Macros   : FAST_MUL_EN - single-cycle combinational multiplier; the MUL
//             state is then never entered.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            result_zero
);

    localparam int              c_SHW      = $clog2(XLEN);
    localparam logic [c_SHW-1:0] c_CNT_ONE  = {{(c_SHW-1){1'b0}}, 1'b1};
    localparam logic [c_SHW-1:0] c_CNT_LAST = {c_SHW{1'b1}};

    generate
        if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0) begin : g_bad_xlen
            $error("alu_exec_unit: XLEN must be >= 8 and a power of 2");
        end
    endgenerate

    logic [1:0]        r_state;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_op;
    logic              r_neg;
    logic              r_neg_rem;
    logic [c_SHW-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_prod;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_divisor;

    logic [4:0]        w_op;
    logic              w_idle;
    logic              w_in_ready;
    logic              w_accept;

    alu_op_decode #(.M_EXT(M_EXT)) u_decode (
        .alu_op (alu_op),
        .funct3 (funct3),
        .funct7 (funct7),
        .op     (w_op)
    );

    assign w_idle     = (r_state == c_ST_IDLE);
    // Gated by rst so the pipe sees no acceptance while reset is held.
    assign w_in_ready = !rst && w_idle && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    // ---------------- base ALU ----------------
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_base_result;

    assign w_shamt = op_b[c_SHW-1:0];

    always_comb begin
        w_base_result = '0;
        case (w_op)
            c_OP_ADD:  w_base_result = op_a + op_b;
            c_OP_SUB:  w_base_result = op_a - op_b;
            c_OP_XOR:  w_base_result = op_a ^ op_b;
            c_OP_OR:   w_base_result = op_a | op_b;
            c_OP_AND:  w_base_result = op_a & op_b;
            c_OP_SLL:  w_base_result = op_a << w_shamt;
            c_OP_SRL:  w_base_result = op_a >> w_shamt;
            c_OP_SRA:  w_base_result = $signed(op_a) >>> w_shamt;
            c_OP_SLT:  w_base_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            c_OP_SLTU: w_base_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:   w_base_result = '0;
        endcase
    end

    // ---------------- operand sign handling ----------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;

    assign w_a_signed = (w_op == c_OP_MULH) || (w_op == c_OP_MULHSU) ||
                        (w_op == c_OP_DIV)  || (w_op == c_OP_REM);
    assign w_b_signed = (w_op == c_OP_MULH) || (w_op == c_OP_DIV) || (w_op == c_OP_REM);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_mag_a    = w_a_neg ? -op_a : op_a;
    assign w_mag_b    = w_b_neg ? -op_b : op_b;

    // ---------------- multiply ----------------
    // In IDLE the step consumes the incoming operands so the accept cycle
    // already performs the first iteration.
    logic [2*XLEN-1:0] w_prod_in;
    logic [2*XLEN-1:0] w_mcand_in;
    logic [XLEN-1:0]   w_mplier_in;
    logic [2*XLEN-1:0] w_prod_step;
    logic [2*XLEN-1:0] w_prod_full;
    logic [2*XLEN-1:0] w_prod_signed;
    logic              w_mul_neg;
    logic [4:0]        w_mul_op;
    logic [XLEN-1:0]   w_mul_result;

    assign w_prod_in   = w_idle ? '0 : r_prod;
    assign w_mcand_in  = w_idle ? {{XLEN{1'b0}}, w_mag_a} : r_mcand;
    assign w_mplier_in = w_idle ? w_mag_b : r_mplier;
    assign w_prod_step = w_prod_in + (w_mplier_in[0] ? w_mcand_in : '0);

`ifdef FAST_MUL_EN
    assign w_prod_full = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`else
    assign w_prod_full = w_prod_step;
`endif

    assign w_mul_neg     = w_idle ? (w_a_neg ^ w_b_neg) : r_neg;
    assign w_mul_op      = w_idle ? w_op : r_op;
    assign w_prod_signed = w_mul_neg ? -w_prod_full : w_prod_full;
    assign w_mul_result  = (w_mul_op == c_OP_MUL) ? w_prod_signed[XLEN-1:0]
                                                  : w_prod_signed[2*XLEN-1:XLEN];

    // ---------------- divide ----------------
    logic [XLEN-1:0] w_rem_in;
    logic [XLEN-1:0] w_quot_in;
    logic [XLEN-1:0] w_dvsr_in;
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN:0]   w_rem_sub;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_step;
    logic [XLEN-1:0] w_quot_step;
    logic            w_div_by_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_corner_result;
    logic            w_quot_sel;
    logic [XLEN-1:0] w_div_result;

    assign w_rem_in    = w_idle ? '0 : r_rem;
    assign w_quot_in   = w_idle ? w_mag_a : r_quot;
    assign w_dvsr_in   = w_idle ? w_mag_b : r_divisor;
    assign w_rem_shift = {w_rem_in, w_quot_in[XLEN-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, w_dvsr_in};
    assign w_fits      = !w_rem_sub[XLEN];
    assign w_rem_step  = w_fits ? w_rem_sub[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quot_step = {w_quot_in[XLEN-2:0], w_fits};

    assign w_div_by_zero = (op_b == '0);
    assign w_div_ovf     = ((w_op == c_OP_DIV) || (w_op == c_OP_REM)) &&
                           (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    always_comb begin
        w_corner_result = '0;
        if (w_div_by_zero)
            w_corner_result = ((w_op == c_OP_DIV) || (w_op == c_OP_DIVU)) ? '1 : op_a;
        else
            w_corner_result = (w_op == c_OP_DIV) ? op_a : '0;
    end

    assign w_quot_sel   = (r_op == c_OP_DIV) || (r_op == c_OP_DIVU);
    assign w_div_result = w_quot_sel ? (r_neg ? -r_quot : r_quot)
                                     : (r_neg_rem ? -r_rem : r_rem);

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_op        <= c_OP_ADD;
            r_neg       <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
        end else if (flush) begin
            r_state     <= c_ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready)
                r_out_valid <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_cnt <= c_CNT_ONE;
                        if (is_div_op(w_op)) begin
                            if (w_div_by_zero || w_div_ovf) begin
                                r_result    <= w_corner_result;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_rem     <= w_rem_step;
                                r_quot    <= w_quot_step;
                                r_divisor <= w_mag_b;
                                r_neg     <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= w_a_neg;
                                r_state   <= c_ST_DIV;
                            end
                        end else if (is_mul_op(w_op)) begin
`ifdef FAST_MUL_EN
                            r_result    <= w_mul_result;
                            r_out_valid <= 1'b1;
`else
                            r_prod   <= w_prod_step;
                            r_mcand  <= w_mcand_in << 1;
                            r_mplier <= w_mplier_in >> 1;
                            r_neg    <= w_a_neg ^ w_b_neg;
                            r_state  <= c_ST_MUL;
`endif
                        end else begin
                            r_result    <= w_base_result;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
`ifndef FAST_MUL_EN
                c_ST_MUL: begin
                    r_prod   <= w_prod_step;
                    r_mcand  <= w_mcand_in << 1;
                    r_mplier <= w_mplier_in >> 1;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        r_result    <= w_mul_result;
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
`endif
                c_ST_DIV: begin
                    r_rem  <= w_rem_step;
                    r_quot <= w_quot_step;
                    r_cnt  <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST)
                        r_state <= c_ST_DONE_DIV;
                end
                c_ST_DONE_DIV: begin
                    r_result    <= w_div_result;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign result_zero = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Directed self-checking bench for alu_exec_unit (XLEN = 32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        result_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(32), .M_EXT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7      (funct7),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_zero (result_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = aop;
        funct3 = f3;
        funct7 = f7;
        op_a   = a;
        op_b   = b;
    endtask

    // Offer one op, wait for the result (out_ready assumed high), check value and latency.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        int lat;
        drive(aop, f3, f7, a, b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready)
            check({tag, "_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check(tag, result, exp);
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(2'b00, 3'd0, 7'd0, 32'd0, 32'd0);

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_result_zero", result_zero, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", in_ready, 1);

        // base ops
        run_op("sub",      2'b10, 3'd0, 7'd32, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
        check("sub_zero", result_zero, 0);
        run_op("bltu",     2'b01, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        check("bltu_zero", result_zero, 1);
        run_op("blt",      2'b01, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
        run_op("beq",      2'b01, 3'd0, 7'd0, 32'd9, 32'd9, 32'd0, 1);
        run_op("srai",     2'b11, 3'd5, 7'd32, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
        run_op("srli",     2'b11, 3'd5, 7'd0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
        run_op("addi_f7",  2'b11, 3'd0, 7'd32, 32'd5, 32'd7, 32'd12, 1);
        run_op("addi_m",   2'b11, 3'd0, 7'd1, 32'd5, 32'd7, 32'd12, 1);
        run_op("sll_mask", 2'b10, 3'd1, 7'd0, 32'd1, 32'h24, 32'd16, 1);
        run_op("sltu",     2'b10, 3'd3, 7'd0, 32'd1, 32'd2, 32'd1, 1);
        run_op("xor",      2'b10, 3'd4, 7'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1);
        run_op("ld_add",   2'b00, 3'd7, 7'd32, 32'd3, 32'd4, 32'd7, 1);

        // multiply
        run_op("mul",    2'b10, 3'd0, 7'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32);
        run_op("mulhu",  2'b10, 3'd3, 7'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run_op("mulhsu", 2'b10, 3'd2, 7'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32);

        // divide corner cases and iterative divides
        run_op("div_ovf",  2'b10, 3'd4, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  2'b10, 3'd6, 7'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu_by0", 2'b10, 3'd5, 7'd1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",  2'b10, 3'd6, 7'd1, 32'd7, 32'd0, 32'd7, 1);
        run_op("rem_neg",  2'b10, 3'd6, 7'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_neg",  2'b10, 3'd4, 7'd1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("div_negb", 2'b10, 3'd4, 7'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_negb", 2'b10, 3'd6, 7'd1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("divu",     2'b10, 3'd5, 7'd1, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu",     2'b10, 3'd7, 7'd1, 32'd100, 32'd7, 32'd2, 33);

        // MULH with a queued ADD behind it and the result held back
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b10, 3'd1, 7'd1, 32'h8000_0000, 32'd2);
        in_valid = 1'b1;
        check("mulh_accept_rdy", in_ready, 1);
        @(posedge clk); #1;
        drive(2'b10, 3'd0, 7'd0, 32'd3, 32'd4);
        lat  = 1;
        seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) seen++;
            @(posedge clk); #1;
            lat++;
        end
        check("mulh", result, 32'hFFFF_FFFF);
        check("mulh_lat", lat, 32);
        check("mulh_busy_rdy", seen, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mulh_hold", result, 32'hFFFF_FFFF);
            check("mulh_hold_rdy", in_ready, 0);
            check("mulh_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("mulh_release_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("add_after_mulh", result, 32'd7);
        check("add_after_mulh_valid", out_valid, 1);

        // backpressure on the ADD result for 5 cycles
        out_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_result", result, 32'd7);
            check("bp_rdy", in_ready, 0);
        end
        drive(2'b10, 3'd1, 7'd0, 32'd1, 32'd3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next", result, 32'd8);
        check("bp_next_valid", out_valid, 1);

        // flush in cycle 10 of a DIVU
        @(posedge clk); #1;
        drive(2'b10, 3'd5, 7'd1, 32'd100, 32'd7);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_rdy", in_ready, 1);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush_no_valid", seen, 0);
        run_op("add_after_flush", 2'b00, 3'd0, 7'd0, 32'd1, 32'd1, 32'd2, 1);

        // async reset in the middle of a MUL
        @(posedge clk); #1;
        drive(2'b10, 3'd0, 7'd1, 32'd3, 32'd5);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_result_zero", result_zero, 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_rdy", in_ready, 1);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check("midrst_no_valid", seen, 0);
        run_op("add_after_rst", 2'b00, 3'd0, 7'd0, 32'd1, 32'd1, 32'd2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode: merges op decode and execution into one handshaked execute unit.
- Decodes alu_op/funct3/funct7, including RV32M (funct7 = 7'd1). Base ALU ops complete in 1 cycle; MUL/DIV run iteratively.
- Sits in the EX stage between the register-read stage and writeback; stalls the pipe via in_ready.

Parameters:
- XLEN, 32, operand/result width; must be ≥8 and a power of 2.
- M_EXT, 1, 1 = decode RV32M ops; 0 = funct7 == 7'd1 decodes as the base op for that funct3.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort: drops the in-flight op and any pending result
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts this cycle
- alu_op  in  2  00 add (ld/st), 01 branch compare, 10 R-type, 11 I-type ALU
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7 (I-type: imm[11:5], used only for SRAI)
- op_a  in  XLEN  rs1 value
- op_b  in  XLEN  rs2 value or immediate
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes the result
- result  out  XLEN  operation result
- result_zero  out  1  result == 0; branch equality flag

Behaviour:
- Reset: state IDLE; out_valid = 0; result = 0; result_zero = 1; in_ready = 0 while rst is high.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Decode to a 5-bit op code:
  - alu_op 00 → ADD.
  - alu_op 01: funct3 0/1 → SUB; 4/5 → SLT; 6/7 → SLTU; other values → SUB.
  - alu_op 10: standard RV32I mapping; funct7 == 7'd32 selects SUB/SRA; funct7 == 7'd1 (when M_EXT = 1) selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU for funct3 0..7.
  - alu_op 11: as alu_op 10, except funct3 0 is always ADD, funct7 is checked only for funct3 5, and M ops never decode.
- Shifts use op_b[$clog2(XLEN)-1:0]. SLT/SLTU results are zero-extended 1/0.
- Base ops: accepted in IDLE; result registered; out_valid rises the next cycle (latency 1). Back-to-back base ops give throughput 1/cycle.
- FSM states:
  - IDLE: on a MUL op → MUL; on a DIV/REM op → DIV; on a base op → stay.
  - MUL: shift-add, XLEN iterations. Full 2·XLEN product; operands sign-handled per variant.
  - DIV: restoring, XLEN iterations on magnitudes, then sign fix → DONE_DIV.
  - DONE_DIV (1 cycle): writes result, sets out_valid → IDLE.
  - MUL also writes in its final iteration cycle, then → IDLE.
- Latency from accept to out_valid: MUL = XLEN cycles; DIV/REM = XLEN+1 cycles.
- Division corner cases (no iteration, result next cycle):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a = −2^(XLEN−1), op_b = −1): DIV → op_a; REM → 0.
- Output hold: while out_valid && !out_ready, result is stable and no new op is accepted.
- flush: forces IDLE and clears out_valid the next edge. It takes priority over a simultaneous accept, and over completion in the same cycle.
- rst mid-operation: returns immediately to reset values; the partial product/quotient is discarded.

Optional Feature:
- FAST_MUL_EN defined: MUL* use a single-cycle combinational XLEN×XLEN multiplier, and the MUL state is unused. MUL latency = 1, same as base ops.
- FAST_MUL_EN undefined: iterative shift-add, XLEN-cycle latency as above. Results are identical in both builds.

Decomposition:
- Package alu_exec_pkg holds:
  - the 5-bit op-code constants: ADD = 0, SUB = 1, XOR = 2, OR = 3, AND = 4, SLL = 5, SRL = 6, SRA = 7, SLT = 8, SLTU = 9, MUL = 16..REMU = 23;
  - the alu_op encodings;
  - the FSM state encoding.
- Sub-module alu_op_decode: combinational decode to the op code, reusable by hazard logic.
- The iterative datapath stays in the top module.

Test Plan:
- R-type SUB, XLEN = 32: op_a = 5, op_b = 7, funct7 = 32 → result = 0xFFFFFFFE one cycle after accept; result_zero = 0.
- Branch BLTU: alu_op 01, funct3 6, op_a = 0xFFFFFFFF, op_b = 1 → result = 0. Then BLT with the same operands → result = 1.
- MULH: op_a = 0x80000000, op_b = 2 → result = 0xFFFFFFFF after 32 cycles. in_ready stays low throughout; a back-to-back ADD is accepted only after the result is taken.
- DIV corner cases:
  - 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - DIVU 7/0 → 0xFFFFFFFF.
  - REM 7/0 → 7.
  - REM −7/2 → 0xFFFFFFFF.
- Backpressure: hold out_ready = 0 for 5 cycles after an ADD → result stable, in_ready = 0. Release → next op accepted that same cycle.
- flush asserted at cycle 10 of a DIVU → out_valid never rises and the unit is back in IDLE; rst pulsed mid-MUL gives the same outcome. The next ADD 1+1 → 2 with latency 1.
